// File: rtl/arb_pkg.sv
// Shared types and helpers for the round-robin channel arbiter.
package arb_pkg;

    typedef enum logic {
        IDLE  = 1'b0,
        GRANT = 1'b1
    } arb_state_t;

    localparam int unsigned HOLD_CNT_W = 16;

    // Mux select width: ceil(log2(m)), never below one bit.
    function automatic int unsigned sel_width(input int unsigned m);
        return (m <= 2) ? 1 : $clog2(m);
    endfunction

endpackage

// File: rtl/rr_channel_arbiter_if.sv
// Request/grant/select bundle between requesters and the channel arbiter.
interface rr_channel_arbiter_if
    import arb_pkg::*;
#(
    parameter int unsigned M = 4
);
    localparam int unsigned SEL_W = sel_width(M);

    logic [M-1:0]     req;
    logic             done;
    logic [M-1:0]     gnt;
    logic [SEL_W-1:0] select;
    logic             busy;
    logic             timeout;

    modport master (output req, output done,
                    input gnt, input select, input busy, input timeout);
    modport slave  (input req, input done,
                    output gnt, output select, output busy, output timeout);
endinterface

// File: rtl/rr_priority_encoder.sv
// Combinational rotate-scan: first set request starting at ptr_i and wrapping.
module rr_priority_encoder
    import arb_pkg::*;
#(
    parameter int unsigned M = 4,
    localparam int unsigned SEL_W = sel_width(M)
) (
    input  logic [M-1:0]     req_i,
    input  logic [SEL_W-1:0] ptr_i,
    output logic [SEL_W-1:0] win_c_o,
    output logic             valid_c_o
);
    logic [SEL_W-1:0] idx;

    // Scan from farthest to nearest so the closest hit to ptr_i is written last.
    always_comb begin
        win_c_o   = '0;
        valid_c_o = 1'b0;
        idx       = '0;
        for (int k = int'(M) - 1; k >= 0; k--) begin
            idx = SEL_W'((32'(ptr_i) + 32'(k)) % 32'(M));
            if (req_i[idx]) begin
                win_c_o   = idx;
                valid_c_o = 1'b1;
            end
        end
    end

endmodule

// File: rtl/rr_channel_arbiter.sv
// Round-robin owner of an M-channel mux select with registered grant/select.
// Optional forced release after HOLD_MAX cycles when ARB_TIMEOUT_EN is defined.
module rr_channel_arbiter
    import arb_pkg::*;
#(
    parameter int unsigned M        = 4,
    parameter int unsigned HOLD_MAX = 16
) (
    input  logic                 clk,
    input  logic                 rst,
    rr_channel_arbiter_if.slave  bus
);
    localparam int unsigned SEL_W = sel_width(M);

    if (M < 2 || M > 128) begin : g_bad_m
        $error("rr_channel_arbiter: M out of range");
    end
    if (HOLD_MAX < 1 || HOLD_MAX > 65535) begin : g_bad_hold
        $error("rr_channel_arbiter: HOLD_MAX out of range");
    end

    arb_state_t       state_q, state_d;
    logic [M-1:0]     gnt_q, gnt_d;
    logic [SEL_W-1:0] sel_q, sel_d;
    logic [SEL_W-1:0] ptr_q, ptr_d;
    logic             busy_q, busy_d;

    logic [M-1:0]     scan_req_c;
    logic [SEL_W-1:0] scan_ptr_c;
    logic [SEL_W-1:0] ptr_next_c;
    logic [SEL_W-1:0] win_c;
    logic             win_vld_c;
    logic             release_c;
    logic             force_c;

`ifdef ARB_TIMEOUT_EN
    logic [HOLD_CNT_W-1:0] cnt_q, cnt_d;
    logic                  timeout_q, timeout_d;

    assign force_c     = (state_q == GRANT) && (cnt_q == HOLD_CNT_W'(HOLD_MAX - 1));
    assign bus.timeout = timeout_q;
`else
    assign force_c     = 1'b0;
    assign bus.timeout = 1'b0;
`endif

    assign ptr_next_c = (sel_q == SEL_W'(M - 1)) ? '0 : sel_q + SEL_W'(1);
    assign release_c  = bus.done || !bus.req[sel_q] || force_c;

    // During a grant the scan starts past the owner and never re-picks it.
    assign scan_req_c = (state_q == GRANT) ? (bus.req & ~gnt_q) : bus.req;
    assign scan_ptr_c = (state_q == GRANT) ? ptr_next_c : ptr_q;

    rr_priority_encoder #(.M(M)) u_enc (
        .req_i     (scan_req_c),
        .ptr_i     (scan_ptr_c),
        .win_c_o   (win_c),
        .valid_c_o (win_vld_c)
    );

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q   <= IDLE;
            gnt_q     <= '0;
            sel_q     <= '0;
            ptr_q     <= '0;
            busy_q    <= 1'b0;
`ifdef ARB_TIMEOUT_EN
            cnt_q     <= '0;
            timeout_q <= 1'b0;
`endif
        end else begin
            state_q   <= state_d;
            gnt_q     <= gnt_d;
            sel_q     <= sel_d;
            ptr_q     <= ptr_d;
            busy_q    <= busy_d;
`ifdef ARB_TIMEOUT_EN
            cnt_q     <= cnt_d;
            timeout_q <= timeout_d;
`endif
        end
    end

    always_comb begin
        state_d   = state_q;
        gnt_d     = gnt_q;
        sel_d     = sel_q;
        ptr_d     = ptr_q;
        busy_d    = busy_q;
`ifdef ARB_TIMEOUT_EN
        cnt_d     = cnt_q;
        timeout_d = 1'b0;
`endif
        unique case (state_q)
            IDLE: begin
                if (win_vld_c) begin
                    state_d = GRANT;
                    gnt_d   = M'(1) << win_c;
                    sel_d   = win_c;
                    busy_d  = 1'b1;
`ifdef ARB_TIMEOUT_EN
                    cnt_d   = '0;
`endif
                end else begin
                    gnt_d   = '0;
                    busy_d  = 1'b0;
                end
            end
            GRANT: begin
                if (release_c) begin
                    ptr_d = ptr_next_c;
`ifdef ARB_TIMEOUT_EN
                    timeout_d = force_c && !bus.done;
                    cnt_d     = '0;
`endif
                    if (win_vld_c) begin
                        gnt_d = M'(1) << win_c;
                        sel_d = win_c;
                    end else begin
                        state_d = IDLE;
                        gnt_d   = '0;
                        busy_d  = 1'b0;
                    end
                end else begin
`ifdef ARB_TIMEOUT_EN
                    cnt_d = cnt_q + HOLD_CNT_W'(1);
`endif
                end
            end
            default: begin
                state_d = IDLE;
                gnt_d   = '0;
                busy_d  = 1'b0;
            end
        endcase
    end

    assign bus.gnt    = gnt_q;
    assign bus.select = sel_q;
    assign bus.busy   = busy_q;

endmodule

// File: tb/tb_rr_channel_arbiter.sv
// Directed plus randomized checks of rr_channel_arbiter against a behavioural model.
// Timeout expectations follow ARB_TIMEOUT_EN as seen by this bench.
module tb_rr_channel_arbiter;

    localparam int unsigned M        = 4;
    localparam int unsigned HOLD_MAX = 3;
`ifdef ARB_TIMEOUT_EN
    localparam bit TMO_EN = 1'b1;
`else
    localparam bit TMO_EN = 1'b0;
`endif

    logic clk = 1'b0;
    logic rst;

    rr_channel_arbiter_if #(.M(M)) bus ();

    rr_channel_arbiter #(.M(M), .HOLD_MAX(HOLD_MAX)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    always #5 clk = ~clk;

    int n_cmp = 0;
    int n_err = 0;

    // Model state: owner index (-1 = none), rotation pointer, cycles held.
    int m_owner, m_ptr, m_hold, m_sel;
    bit m_tmo;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    function automatic int scan(input logic [M-1:0] r, input int start, input int excl);
        for (int k = 0; k < int'(M); k++) begin
            int j;
            j = (start + k) % int'(M);
            if (((r >> j) & 1) != 0 && j != excl) return j;
        end
        return -1;
    endfunction

    task automatic model_reset();
        m_owner = -1;
        m_ptr   = 0;
        m_hold  = 0;
        m_sel   = 0;
        m_tmo   = 1'b0;
    endtask

    task automatic model_step(input logic [M-1:0] r, input logic d);
        int w;
        bit tmo;
        m_tmo = 1'b0;
        if (m_owner < 0) begin
            w = scan(r, m_ptr, -1);
            if (w >= 0) begin
                m_owner = w;
                m_sel   = w;
                m_hold  = 0;
            end
        end else begin
            tmo = TMO_EN && (m_hold == int'(HOLD_MAX) - 1);
            if (d || ((r >> m_owner) & 1) == 0 || tmo) begin
                m_tmo  = tmo && !d;
                m_ptr  = (m_owner + 1) % int'(M);
                w      = scan(r, m_ptr, m_owner);
                m_owner = w;
                if (w >= 0) m_sel = w;
                m_hold = 0;
            end else begin
                m_hold++;
            end
        end
    endtask

    task automatic check_model(input string tag);
        logic [31:0] eg;
        eg = (m_owner < 0) ? 32'd0 : (32'd1 << m_owner);
        chk({tag, ".gnt"},     32'(bus.gnt),     eg);
        chk({tag, ".busy"},    32'(bus.busy),    32'(m_owner >= 0));
        chk({tag, ".timeout"}, 32'(bus.timeout), 32'(m_tmo));
        if (m_owner >= 0) chk({tag, ".select"}, 32'(bus.select), 32'(m_sel));
    endtask

    // One clock: drive inputs, clock the model alongside the DUT, check after the edge.
    task automatic cycle(input logic [M-1:0] r, input logic d, input string tag);
        bus.req  = r;
        bus.done = d;
        @(posedge clk);
        model_step(r, d);
        #1;
        check_model(tag);
    endtask

    initial begin
        rst      = 1'b1;
        bus.req  = '0;
        bus.done = 1'b0;
        model_reset();
        #1;
        check_model("reset");
        @(posedge clk);
        #1;
        rst = 1'b0;

        for (int i = 0; i < 5; i++) begin
            cycle(4'b0000, 1'b0, "idle");
            chk("idle.gnt0", 32'(bus.gnt), 32'd0);
        end
        cycle(4'b0000, 1'b1, "idle_done");

        // Rotation across two requesters with back-to-back handoff.
        cycle(4'b1010, 1'b0, "rr1");
        chk("rr1.gnt", 32'(bus.gnt), 32'b0010);
        chk("rr1.sel", 32'(bus.select), 32'd1);
        cycle(4'b1010, 1'b1, "rr2");
        chk("rr2.gnt", 32'(bus.gnt), 32'b1000);
        chk("rr2.sel", 32'(bus.select), 32'd3);
        cycle(4'b1010, 1'b1, "rr3");
        chk("rr3.gnt", 32'(bus.gnt), 32'b0010);
        chk("rr3.sel", 32'(bus.select), 32'd1);
        cycle(4'b0000, 1'b0, "rr_drop");
        chk("rr_drop.busy", 32'(bus.busy), 32'd0);

        // Bring the pointer back to 0 by releasing channel 3.
        cycle(4'b1000, 1'b0, "park3");
        cycle(4'b0000, 1'b0, "park_idle");

        cycle(4'b1111, 1'b0, "all0");
        chk("all.sel0", 32'(bus.select), 32'd0);
        for (int i = 1; i <= 5; i++) begin
            cycle(4'b1111, 1'b1, "all");
            chk("all.sel", 32'(bus.select), 32'(i % 4));
        end

        // Owner 2 drops its request while channel 0 waits.
        cycle(4'b1111, 1'b1, "own2");
        chk("own2.sel", 32'(bus.select), 32'd2);
        cycle(4'b0001, 1'b0, "drop2");
        chk("drop2.gnt", 32'(bus.gnt), 32'b0001);

        // Asynchronous reset in the middle of a grant to channel 3.
        cycle(4'b1001, 1'b1, "to3");
        chk("to3.sel", 32'(bus.select), 32'd3);
        rst = 1'b1;
        #1;
        model_reset();
        chk("arst.gnt",  32'(bus.gnt),  32'd0);
        chk("arst.busy", 32'(bus.busy), 32'd0);
        @(posedge clk);
        #1;
        bus.req = 4'b1111;
        rst = 1'b0;
        cycle(4'b1111, 1'b0, "post_rst");
        chk("post_rst.sel", 32'(bus.select), 32'd0);

        // Long hold on channel 0 with channel 1 waiting.
        cycle(4'b1111, 1'b1, "pre_hold");
        cycle(4'b1000, 1'b1, "pre_hold3");
        cycle(4'b0000, 1'b0, "pre_hold_idle");
        if (TMO_EN) begin
            for (int i = 0; i < int'(HOLD_MAX); i++) begin
                cycle(4'b0011, 1'b0, "hold");
                chk("hold.gnt", 32'(bus.gnt), 32'b0001);
                chk("hold.tmo", 32'(bus.timeout), 32'd0);
            end
            cycle(4'b0011, 1'b0, "tmo");
            chk("tmo.gnt", 32'(bus.gnt), 32'b0010);
            chk("tmo.pulse", 32'(bus.timeout), 32'd1);
            cycle(4'b0011, 1'b0, "tmo_after");
            chk("tmo_after.pulse", 32'(bus.timeout), 32'd0);
        end else begin
            for (int i = 0; i < 50; i++) begin
                cycle(4'b0011, 1'b0, "hold");
                chk("hold.gnt", 32'(bus.gnt), 32'b0001);
                chk("hold.tmo", 32'(bus.timeout), 32'd0);
            end
        end

        // Randomized traffic: requests mostly stable, occasional churn and releases.
        begin
            logic [M-1:0] r;
            r = M'($urandom);
            for (int i = 0; i < 600; i++) begin
                if ($urandom_range(0, 3) == 0) r = M'($urandom);
                cycle(r, 1'($urandom_range(0, 3) == 0), "rand");
                chk("rand.sel_range", 32'(bus.select < 2'(M - 1) || bus.select == 2'(M - 1)), 32'd1);
            end
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
